lfsr_range_sampler: RTL

Downstream consumer of the `lfsr` generator. Takes raw WIDTH-bit pseudo-random words and slices each into BITS-bit chunks, LSB first. It performs rejection sampling so every emitted value is uniformly distributed in [0, LIMIT), and buffers accepted values in a small FIFO behind a valid/ready output port. Upstream is a valid/ready word input, so the generator can be gated or free-running.

---
 rtl/rng_pkg.sv | 22 ++
 rtl/rng_fifo.sv | 63 ++++++
 rtl/lfsr_range_sampler.sv | 86 ++++++++
 3 files changed

// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared constants, clog2 helper and sampler state type for the rng blocks
package rng_pkg;

  localparam int RNG_WIDTH = 32;
  localparam int RNG_LIMIT = 100;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } sampler_state_t;

  // Bits needed to index 'value' distinct items; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rng_fifo.sv
// rtl/rng_fifo.sv - synchronous FIFO whose read data is a register always holding the head entry
module rng_fifo
  import rng_pkg::*;
#(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Keep pop_data equal to whatever will be the head after this cycle.
      if (empty && do_push) begin
        pop_data <= push_data;
      end else if (do_pop) begin
        if (count > 1)    pop_data <= mem[rd_next];
        else if (do_push) pop_data <= push_data;
      end
    end
  end

endmodule

// File: rtl/lfsr_range_sampler.sv
// rtl/lfsr_range_sampler.sv - slices random words into chunks, rejects chunks >= LIMIT, queues the rest
module lfsr_range_sampler
  import rng_pkg::*;
#(
  parameter int WIDTH = RNG_WIDTH,
  parameter int LIMIT = RNG_LIMIT,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [clog2(LIMIT)-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              reject_count
);

  localparam int BITS   = clog2(LIMIT);
  localparam int CHUNKS = WIDTH / BITS;
  localparam int IDXW   = (CHUNKS > 1) ? clog2(CHUNKS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);
  localparam logic [BITS:0]   LIMIT_V  = (BITS + 1)'(LIMIT);

  sampler_state_t  state;
  logic [WIDTH-1:0] word;
  logic [IDXW-1:0]  idx;

  logic [BITS-1:0] chunk;
  logic            scanning;
  logic            accept;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            push_ok;
  logic            push;
  logic            chunk_done;
  logic            last;

  assign chunk      = word[idx*BITS +: BITS];
  assign scanning   = (state == SCAN);
  assign accept     = ({1'b0, chunk} < LIMIT_V);
  assign pop        = !fifo_empty && out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok    = !fifo_full || pop;
  assign push       = scanning && accept && push_ok;
  assign chunk_done = scanning && (!accept || push_ok);
  assign last       = (idx == LAST_IDX);
  assign in_ready   = (state == IDLE) || (chunk_done && last);
  assign out_valid  = !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      word         <= '0;
      idx          <= '0;
      reject_count <= '0;
    end else begin
      if (scanning && !accept) reject_count <= reject_count + 16'd1;
      if (in_valid && in_ready) begin
        word  <= in_data;
        idx   <= '0;
        state <= SCAN;
      end else if (chunk_done) begin
        if (last) state <= IDLE;
        else      idx   <= idx + 1'b1;
      end
    end
  end

  rng_fifo #(
    .W     (BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (chunk),
    .pop       (pop),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
